// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Package : lfsr_pkg
// Brief   : Shared constants, tap table and shift helper for the LFSR generator.
// Rev     : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int LFSR_MIN_WIDTH = 3;
    localparam int LFSR_MAX_WIDTH = 32;

    typedef logic [LFSR_MAX_WIDTH-1:0] lfsr_word_t;

    // Next-state action chosen each cycle, in priority order below reset.
    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_GUARD = 2'd2,
        ACT_XFER  = 2'd3
    } lfsr_act_t;

    // Maximal-length feedback masks, bit i set means state[i] joins the XOR.
    function automatic lfsr_word_t lfsr_default_taps(input int width);
        lfsr_word_t taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0E08;
            13:      taps = 32'h0000_1C80;
            14:      taps = 32'h0000_3802;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_B400;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0007_2000;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = '0;
        endcase
        return taps;
    endfunction

    // One Fibonacci shift on a zero-extended word; callers keep the low WIDTH bits.
    function automatic lfsr_word_t lfsr_shift(input lfsr_word_t state, input lfsr_word_t taps);
        return {state[LFSR_MAX_WIDTH-2:0], ^(state & taps)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ============================================================================
// Module : lfsr_step
// Brief  : Combinational single Fibonacci LFSR shift.
// Rev    : 1.0 - initial release
// ============================================================================
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_state
);

    localparam lfsr_word_t C_TAPS_EXT = lfsr_word_t'(TAPS);

    assign o_state = WIDTH'(lfsr_shift(lfsr_word_t'(i_state), C_TAPS_EXT));

endmodule
`default_nettype wire

// File: rtl/lfsr_prng.sv
`default_nettype none
// ============================================================================
// Module : lfsr_prng
// Brief  : Parametrised Fibonacci-LFSR word generator with valid/ready output,
//          seed loading, zero-seed and lock-up protection, and period tracking.
// Rev    : 1.0 - initial release
// ============================================================================
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] RESET_SEED = '1,
    parameter int               STEPS      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             rand_ready,
    output logic             rand_valid,
    output logic [WIDTH-1:0] rand_data,
    output logic             wrap,
    output logic [WIDTH-1:0] period_len,
    output logic             seed_err
);

    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ONES = '1;

    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
        $error("lfsr_prng: WIDTH must be within 3..32");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_prng: STEPS must be within 1..WIDTH");
    end
    if (RESET_SEED == '0) begin : g_bad_seed
        $error("lfsr_prng: RESET_SEED must be nonzero");
    end

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_len_q, period_len_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             seed_err_q, seed_err_d;

    logic [WIDTH-1:0] w_chain [0:STEPS];
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_val;
    logic             w_seed_zero;
    logic             w_xfer;
    lfsr_act_t        w_act;

    assign w_chain[0] = state_q;

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .i_state (w_chain[i]),
            .o_state (w_chain[i+1])
        );
    end

    assign w_next      = w_chain[STEPS];
    assign w_seed_zero = (seed == '0);
    assign w_load_val  = w_seed_zero ? RESET_SEED : seed;
    assign w_xfer      = rand_valid && rand_ready;

    always_comb begin
        w_act = ACT_HOLD;
        if (load) begin
            w_act = ACT_LOAD;
        end else if (state_q == '0) begin
            w_act = ACT_GUARD;
        end else if (w_xfer) begin
            w_act = ACT_XFER;
        end
    end

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        cnt_d        = cnt_q;
        period_len_d = period_len_q;
        valid_d      = 1'b1;
        wrap_d       = 1'b0;
        seed_err_d   = 1'b0;
        case (w_act)
            ACT_LOAD: begin
                state_d    = w_load_val;
                ref_d      = w_load_val;
                cnt_d      = '0;
                seed_err_d = w_seed_zero;
            end
            ACT_GUARD: begin
                // A non-primitive mask can reach the all-zero dead state; restart from ref.
                state_d = ref_q;
            end
            ACT_XFER: begin
                state_d = w_next;
                if (w_next == ref_q) begin
                    wrap_d       = 1'b1;
                    period_len_d = (cnt_q == C_ONES) ? C_ONES : cnt_q + C_ONE;
                    cnt_d        = '0;
                end else if (cnt_q != C_ONES) begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_SEED;
            ref_q        <= RESET_SEED;
            cnt_q        <= '0;
            period_len_q <= '0;
            valid_q      <= 1'b0;
            wrap_q       <= 1'b0;
            seed_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            cnt_q        <= cnt_d;
            period_len_q <= period_len_d;
            valid_q      <= valid_d;
            wrap_q       <= wrap_d;
            seed_err_q   <= seed_err_d;
        end
    end

    assign rand_valid = valid_q && !load;
    assign rand_data  = state_q;
    assign wrap       = wrap_q;
    assign period_len = period_len_q;
    assign seed_err   = seed_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prng.sv
`default_nettype none
// ============================================================================
// Module : tb_lfsr_prng
// Brief  : Directed self-checking bench for lfsr_prng (3-bit x1, 3-bit x2, 8-bit).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_lfsr_prng;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 3-bit, one shift per transfer
    logic       a_reset, a_load, a_ready, a_valid, a_wrap, a_serr;
    logic [2:0] a_seed, a_data, a_period;
    // 3-bit, two shifts per transfer
    logic       b_reset, b_load, b_ready, b_valid, b_wrap, b_serr;
    logic [2:0] b_seed, b_data, b_period;
    // 8-bit default configuration
    logic       c_reset, c_load, c_ready, c_valid, c_wrap, c_serr;
    logic [7:0] c_seed, c_data, c_period;

    lfsr_prng #(.WIDTH(3), .TAPS(3'b110), .RESET_SEED(3'b111), .STEPS(1)) u_dut_a (
        .clk(clk), .reset(a_reset), .load(a_load), .seed(a_seed), .rand_ready(a_ready),
        .rand_valid(a_valid), .rand_data(a_data), .wrap(a_wrap), .period_len(a_period),
        .seed_err(a_serr)
    );

    lfsr_prng #(.WIDTH(3), .TAPS(3'b110), .RESET_SEED(3'b111), .STEPS(2)) u_dut_b (
        .clk(clk), .reset(b_reset), .load(b_load), .seed(b_seed), .rand_ready(b_ready),
        .rand_valid(b_valid), .rand_data(b_data), .wrap(b_wrap), .period_len(b_period),
        .seed_err(b_serr)
    );

    lfsr_prng #(.WIDTH(8), .TAPS(8'hB8), .RESET_SEED(8'hFF), .STEPS(1)) u_dut_c (
        .clk(clk), .reset(c_reset), .load(c_load), .seed(c_seed), .rand_ready(c_ready),
        .rand_valid(c_valid), .rand_data(c_data), .wrap(c_wrap), .period_len(c_period),
        .seed_err(c_serr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       load;
        logic [2:0] seed;
        logic       ready;
        logic [2:0] data;
        logic       valid;
        logic       wrap;
        logic [2:0] period;
        logic       serr;
    } vec_t;

    vec_t vecs [25];

    initial begin
        logic [2:0] b_exp [8];
        logic [7:0] c_head [6];
        int         zero_seen;
        int         early_wrap;

        // load, seed, ready | data, valid, wrap, period, seed_err (seen before the edge)
        vecs[0]  = '{0, 0, 1, 7, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 7, 1, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 6, 1, 0, 0, 0};
        vecs[3]  = '{0, 0, 1, 4, 1, 0, 0, 0};
        vecs[4]  = '{0, 0, 1, 1, 1, 0, 0, 0};
        vecs[5]  = '{0, 0, 1, 2, 1, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 5, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 1, 3, 1, 0, 0, 0};
        vecs[8]  = '{0, 0, 1, 7, 1, 1, 7, 0};
        vecs[9]  = '{1, 2, 1, 6, 0, 0, 7, 0};
        vecs[10] = '{0, 0, 1, 2, 1, 0, 7, 0};
        vecs[11] = '{0, 0, 1, 5, 1, 0, 7, 0};
        vecs[12] = '{0, 0, 1, 3, 1, 0, 7, 0};
        vecs[13] = '{0, 0, 1, 7, 1, 0, 7, 0};
        vecs[14] = '{0, 0, 1, 6, 1, 0, 7, 0};
        vecs[15] = '{0, 0, 1, 4, 1, 0, 7, 0};
        vecs[16] = '{0, 0, 1, 1, 1, 0, 7, 0};
        vecs[17] = '{1, 0, 1, 2, 0, 1, 7, 0};
        vecs[18] = '{0, 0, 1, 7, 1, 0, 7, 1};
        vecs[19] = '{0, 0, 0, 6, 1, 0, 7, 0};
        vecs[20] = '{0, 0, 0, 6, 1, 0, 7, 0};
        vecs[21] = '{0, 0, 1, 6, 1, 0, 7, 0};
        vecs[22] = '{0, 0, 0, 4, 1, 0, 7, 0};
        vecs[23] = '{0, 0, 1, 4, 1, 0, 7, 0};
        vecs[24] = '{0, 0, 0, 1, 1, 0, 7, 0};

        b_exp  = '{3'd7, 3'd4, 3'd2, 3'd3, 3'd6, 3'd1, 3'd5, 3'd7};
        c_head = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};

        a_reset = 1; a_load = 0; a_seed = 0; a_ready = 0;
        b_reset = 1; b_load = 0; b_seed = 0; b_ready = 0;
        c_reset = 1; c_load = 0; c_seed = 0; c_ready = 0;
        repeat (2) @(posedge clk);

        // --- 3-bit STEPS=1 vector table ---
        @(negedge clk);
        a_reset = 0;
        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge clk);
            a_load  = vecs[i].load;
            a_seed  = vecs[i].seed;
            a_ready = vecs[i].ready;
            #1;
            chk($sformatf("a_data[%0d]", i),   32'(a_data),   32'(vecs[i].data));
            chk($sformatf("a_valid[%0d]", i),  32'(a_valid),  32'(vecs[i].valid));
            chk($sformatf("a_wrap[%0d]", i),   32'(a_wrap),   32'(vecs[i].wrap));
            chk($sformatf("a_period[%0d]", i), 32'(a_period), 32'(vecs[i].period));
            chk($sformatf("a_serr[%0d]", i),   32'(a_serr),   32'(vecs[i].serr));
        end

        // --- 3-bit STEPS=2 free run ---
        @(negedge clk);
        b_reset = 0; b_ready = 1;
        #1;
        chk("b_valid_after_reset", 32'(b_valid), 32'd0);
        chk("b_data_after_reset",  32'(b_data),  32'd7);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("b_data[%0d]", k),   32'(b_data),   32'(b_exp[k]));
            chk($sformatf("b_valid[%0d]", k),  32'(b_valid),  32'd1);
            chk($sformatf("b_wrap[%0d]", k),   32'(b_wrap),   (k == 7) ? 32'd1 : 32'd0);
            chk($sformatf("b_period[%0d]", k), 32'(b_period), (k == 7) ? 32'd7 : 32'd0);
        end

        // --- 8-bit full period ---
        @(negedge clk);
        c_reset = 0; c_ready = 1;
        #1;
        chk("c_valid_after_reset", 32'(c_valid), 32'd0);
        zero_seen  = 0;
        early_wrap = 0;
        for (int t = 0; t < 255; t++) begin
            @(negedge clk);
            #1;
            if (t < 6) chk($sformatf("c_head[%0d]", t), 32'(c_data), 32'(c_head[t]));
            if (c_data == 8'h00) zero_seen++;
            if (c_wrap) early_wrap++;
        end
        chk("c_zero_states", 32'(zero_seen),  32'd0);
        chk("c_early_wrap",  32'(early_wrap), 32'd0);
        @(negedge clk);
        #1;
        chk("c_wrap_255",   32'(c_wrap),   32'd1);
        chk("c_period_255", 32'(c_period), 32'd255);
        chk("c_data_255",   32'(c_data),   32'hFF);
        repeat (10) @(negedge clk);
        #1;
        chk("c_wrap_cleared", 32'(c_wrap), 32'd0);

        // --- reset mid-run ---
        c_reset = 1;
        @(negedge clk);
        c_reset = 0;
        #1;
        chk("c_rst_data",   32'(c_data),   32'hFF);
        chk("c_rst_valid",  32'(c_valid),  32'd0);
        chk("c_rst_period", 32'(c_period), 32'd0);
        chk("c_rst_wrap",   32'(c_wrap),   32'd0);
        @(negedge clk);
        #1;
        chk("c_rst_valid_back", 32'(c_valid), 32'd1);
        chk("c_rst_hold_data",  32'(c_data),  32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_prng.md
# lfsr_prng

Parametrised pseudo-random word generator built on a Fibonacci LFSR. It generalises the team's fixed 3-bit shift-register generator to any width from 3 to 32 bits with a configurable tap mask. It also adds multi-step advance, zero-seed protection, a valid/ready output handshake, and period measurement. It feeds test-pattern, dither and scrambler consumers that pull one word per transfer.

## Interface
- WIDTH, 8: LFSR/state width, 3..32.
- TAPS, 8'hB8: feedback mask, WIDTH bits; bit i set means state[i] is XORed into feedback.
- RESET_SEED, all ones: state after reset; nonzero (elaboration error if zero).
- STEPS, 1: LFSR shifts per transfer, 1..WIDTH.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- load  in  1  load seed this cycle.
- seed  in  WIDTH  seed value, sampled when load=1.
- rand_ready  in  1  consumer accepts rand_data.
- rand_valid  out  1  rand_data is available.
- rand_data  out  WIDTH  current LFSR state.
- wrap  out  1  one-cycle pulse when the sequence returns to its reference seed.
- period_len  out  WIDTH  transfers counted in the last completed period.
- seed_err  out  1  one-cycle pulse when a zero seed was loaded.

## Operation
- One shift: next = {state[WIDTH-2:0], ^(state & TAPS)}. STEPS shifts are applied combinationally per transfer.
- Transfer: rand_valid && rand_ready at a rising edge. The state advances by STEPS shifts; otherwise it holds.
- Reset values: state=RESET_SEED, valid_q=0, ref=RESET_SEED, cnt=0, period_len=0, wrap=0, seed_err=0.
- valid_q becomes 1 on the first edge with reset=0 and stays 1. rand_valid = valid_q && !load.
- load=1:
  - state <= seed, or RESET_SEED if seed==0.
  - ref <= the same value; cnt <= 0.
  - seed_err <= (seed==0).
  - No transfer occurs, regardless of rand_ready.
- Period tracking:
  - Each transfer increments cnt.
  - If a transfer's next state equals ref: wrap <= 1, period_len <= cnt+1, cnt <= 0.
  - wrap and seed_err are otherwise 0.
- Counter width: cnt is WIDTH bits. Maximum period 2^WIDTH-1 fits; cnt saturates at all-ones if ref is never revisited (non-maximal TAPS).
- Lock-up guard: if state is ever 0 (non-primitive TAPS), the next edge forces state <= ref, without a transfer or wrap.
- Priority: reset > load > lock-up guard > transfer > hold.

## Timing
- rand_data is registered: it equals state directly, with no output logic.
- Load at edge N: rand_data=seed (or RESET_SEED) from N; rand_valid=1 from N unless load is still high.
- Transfer at edge N: new word visible after N; back-to-back transfers each cycle at full rate.
- wrap and period_len update on the same edge as the closing transfer.
- seed_err is high for the single cycle after the load edge.
- Reset mid-sequence: all registers return to reset values at that edge; rand_valid=0 for the cycle after.
- rand_ready held low: rand_data, cnt and state are stable indefinitely.

## Structure
- Package lfsr_pkg:
  - default tap constants for widths 3..32 (e.g. 3'b110, 8'hB8, 16'hB400, 32'h80200003);
  - function lfsr_shift(state, taps).
- Sub-module lfsr_step: combinational single shift, instantiated STEPS times in a generate chain.
- Top holds state, ref, cnt, flags and handshake logic (about 150-250 lines).

## Test plan
- WIDTH=3, TAPS=3'b110, STEPS=1, reset then rand_ready=1: rand_data = 7,6,4,1,2,5,3,7.
  - wrap pulses on the 7th transfer; period_len=7.
- Same configuration, STEPS=2: rand_data = 7,4,2,3,6,1,5,7.
  - wrap on the 7th transfer; period_len=7.
- Load seed=3'b010 with rand_ready=1:
  - rand_valid=0 in the load cycle; next words are 2,5,3,7,6,4,1,2; wrap on return to 2.
- Load seed=0: state becomes RESET_SEED, seed_err pulses one cycle, sequence restarts from 7.
- rand_ready toggling 1,0,0,1: state advances only on ready-high edges; rand_data is stable while ready=0.
- WIDTH=8, TAPS=8'hB8: free-run 255 transfers.
  - No zero state; wrap on transfer 255; period_len=255.
  - Reset asserted mid-run returns rand_data to 8'hFF.
